// File: rtl/circuit7_arbiter.sv
// circuit7_arbiter
//   Round-robin arbiter in front of one shared, registered inverting stage.
//   Each cycle at most one requester is granted. Its data bit is inverted and
//   registered, together with its index, so the result appears one cycle later.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   aresetn    : asynchronous active-low reset
//   req_valid  : [N] per-requester request strobe
//   req_a      : [N] per-requester data bit
//   hold       : blocks all grants for the current cycle
//   req_ready  : [N] one-hot grant (or zero), combinational
//   q_valid    : registered result valid
//   q          : registered ~req_a of the granted requester
//   q_id       : [IDW] registered index of the granted requester
//   grant_cnt  : [8] registered count of accepted requests, saturates at 255
module circuit7_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2   // must equal ceil(log2(N))
) (
  input  logic           clk,
  input  logic           aresetn,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_a,
  input  logic           hold,
  output logic [N-1:0]   req_ready,
  output logic           q_valid,
  output logic           q,
  output logic [IDW-1:0] q_id,
  output logic [7:0]     grant_cnt
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           q_valid_q;
  logic           q_q;
  logic [IDW-1:0] q_id_q;
  logic [7:0]     cnt_q, cnt_d;

  logic           found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] scan_idx;
  logic           grant;

  // Scan from ptr upward with wrap; the first valid lane wins.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IDW'((32'(ptr_q) + 32'(k)) % 32'(N));
      if (!found && req_valid[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // aresetn is folded in so no handshake can be signalled while in reset.
  assign grant = found && !hold && aresetn;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (grant && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q     <= '0;
      q_valid_q <= 1'b0;
      q_q       <= 1'b0;
      q_id_q    <= '0;
      cnt_q     <= 8'd0;
    end else begin
      ptr_q     <= ptr_d;
      q_valid_q <= grant;
      cnt_q     <= cnt_d;
      // Result and id only load on a grant, so idle cycles keep the last
      // result and never sample data from a non-granted lane.
      if (grant) begin
        q_q    <= ~req_a[gnt_idx];
        q_id_q <= gnt_idx;
      end
    end
  end

  assign q_valid   = q_valid_q;
  assign q         = q_q;
  assign q_id      = q_id_q;
  assign grant_cnt = cnt_q;

endmodule
